// File: rtl/nsc8_computer.sv
// NSC-8 accumulator computer: PC, one-hot T1..T6 ring sequencer, IR, A, B, OUT around a 16-word ROM.
// Define NSC8_HLT_EN to make opcode 0xF halt the machine; otherwise 0xF is a NOP and the program loops.
module nsc8_computer #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset_counter,
  input  logic         reset_ring,
  input  logic         clear_ir,
  output logic [N-1:0] output_contents
);

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } ring_t;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  ring_t        ring, ring_next;
  logic [3:0]   pc, mar, opcode;
  logic [N-1:0] ir, a, b, out_reg, rom_data;
  logic         run, halt_set;
  logic         mar_from_pc, mar_from_ir, pc_inc, ir_load;
  logic         a_load, b_load, a_add, a_sub, out_load;

  assign opcode          = ir[N-1:N-4];
  assign output_contents = out_reg;

  function automatic logic [N-1:0] instr(input logic [3:0] op, input logic [3:0] addr);
    logic [N-1:0] w;
    w         = '0;
    w[N-1:N-4] = op;
    w[3:0]    = addr;
    return w;
  endfunction

  always_comb begin
    rom_data = '0;
    case (mar)
      4'h0:    rom_data = instr(OP_LDA, 4'h9);
      4'h1:    rom_data = instr(OP_ADD, 4'hA);
      4'h2:    rom_data = instr(OP_ADD, 4'hB);
      4'h3:    rom_data = instr(OP_SUB, 4'hC);
      4'h4:    rom_data = instr(OP_OUT, 4'h0);
      4'h5:    rom_data = instr(OP_HLT, 4'h0);
      4'h9:    rom_data = N'(8'h10);
      4'hA:    rom_data = N'(8'h14);
      4'hB:    rom_data = N'(8'h18);
      4'hC:    rom_data = N'(8'h04);
      default: rom_data = '0;
    endcase
  end

`ifdef NSC8_HLT_EN
  logic halt;

  // Halt is raised at the HLT T4 edge, which also freezes the ring at T4.
  assign halt_set = (ring == T4) && (opcode == OP_HLT) && !halt;
  assign run      = !halt;

  always_ff @(posedge clk) begin
    if (reset_ring)    halt <= 1'b0;
    else if (halt_set) halt <= 1'b1;
  end
`else
  assign halt_set = 1'b0;
  assign run      = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset_ring) ring <= T1;
    else            ring <= ring_next;
  end

  always_comb begin
    ring_next = ring;
    if (run && !halt_set) begin
      case (ring)
        T1:      ring_next = T2;
        T2:      ring_next = T3;
        T3:      ring_next = T4;
        T4:      ring_next = T5;
        T5:      ring_next = T6;
        default: ring_next = T1;
      endcase
    end
  end

  always_comb begin
    mar_from_pc = 1'b0;
    mar_from_ir = 1'b0;
    pc_inc      = 1'b0;
    ir_load     = 1'b0;
    a_load      = 1'b0;
    b_load      = 1'b0;
    a_add       = 1'b0;
    a_sub       = 1'b0;
    out_load    = 1'b0;
    if (run) begin
      case (ring)
        T1: mar_from_pc = 1'b1;
        T2: pc_inc      = 1'b1;
        T3: ir_load     = 1'b1;
        T4: begin
          mar_from_ir = (opcode == OP_LDA) || (opcode == OP_ADD) || (opcode == OP_SUB);
          out_load    = (opcode == OP_OUT);
        end
        T5: begin
          a_load = (opcode == OP_LDA);
          b_load = (opcode == OP_ADD) || (opcode == OP_SUB);
        end
        T6: begin
          a_add = (opcode == OP_ADD);
          a_sub = (opcode == OP_SUB);
        end
        default: ;
      endcase
    end
  end

  // Each reset only touches its own registers; everything else keeps executing.
  always_ff @(posedge clk) begin
    if (reset_counter) begin
      pc      <= '0;
      mar     <= '0;
      a       <= '0;
      b       <= '0;
      out_reg <= '0;
    end else begin
      if (mar_from_pc)      mar <= pc;
      else if (mar_from_ir) mar <= ir[3:0];
      if (pc_inc)           pc <= pc + 4'd1;
      if (a_load)           a <= rom_data;
      else if (a_add)       a <= a + b;
      else if (a_sub)       a <= a - b;
      if (b_load)           b <= rom_data;
      if (out_load)         out_reg <= a;
    end
  end

  always_ff @(posedge clk) begin
    if (clear_ir)     ir <= '0;
    else if (ir_load) ir <= rom_data;
  end

  generate
    if (N > 8) begin : g_spare_ir
      logic unused_ir_bits;
      assign unused_ir_bits = ^ir[N-5:4];
    end
  endgenerate

endmodule

// File: tb/tb_nsc8_computer.sv
// Scoreboard bench for nsc8_computer: stimulus queues the expected output_contents per edge,
// a negedge monitor pops and compares. Expectations for halt behaviour follow NSC8_HLT_EN.
module tb_nsc8_computer;

  logic       clk = 1'b0;
  logic       reset_counter = 1'b0;
  logic       reset_ring = 1'b0;
  logic       clear_ir = 1'b0;
  logic [7:0] output_contents;

  typedef struct {
    logic [7:0] value;
    string      name;
    int         edge_no;
  } exp_t;

  exp_t sb[$];
  exp_t mon_item;
  int   check_count = 0;
  int   pass_count = 0;

  nsc8_computer #(.N(8)) dut (
    .clk             (clk),
    .reset_counter   (reset_counter),
    .reset_ring      (reset_ring),
    .clear_ir        (clear_ir),
    .output_contents (output_contents)
  );

  always #5 clk = ~clk;

  // Drive one edge worth of inputs and queue the output expected after that edge.
  task automatic apply_stimulus(input logic rc, input logic rr, input logic ci,
                                input logic [7:0] expv, input string name, input int edge_no);
    exp_t item;
    reset_counter = rc;
    reset_ring    = rr;
    clear_ir      = ci;
    @(posedge clk);
    item.value   = expv;
    item.name    = name;
    item.edge_no = edge_no;
    sb.push_back(item);
    @(negedge clk);
  endtask

  task automatic check_output(input exp_t item);
    check_count++;
    if (output_contents === item.value) pass_count++;
    else $display("[TB] FAIL %s edge %0d: output_contents=%h expected %h",
                  item.name, item.edge_no, output_contents, item.value);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_item = sb.pop_front();
      check_output(mon_item);
    end
  end

  initial begin
    @(negedge clk);

    // Full reset, then the default program: 0x10+0x14+0x18-0x04 = 0x38 appears at edge 28.
    apply_stimulus(1'b1, 1'b1, 1'b1, 8'h00, "reset", 0);
    for (int e = 1; e <= 126; e++)
      apply_stimulus(1'b0, 1'b0, 1'b0, (e >= 28) ? 8'h38 : 8'h00, "run", e);

`ifdef NSC8_HLT_EN
    // Halted since edge 34: reset_counter clears OUT, ring stays frozen until reset_ring.
    for (int e = 127; e <= 175; e++)
      apply_stimulus((e == 127), (e == 141), 1'b0, (e >= 169) ? 8'h38 : 8'h00, "halt_restart", e);
`else
    // Edge 127 is a T1 edge: program restarts at 0, OUT reached at T4 of instr 4 = edge 154.
    for (int e = 127; e <= 160; e++)
      apply_stimulus((e == 127), 1'b0, 1'b0, (e >= 154) ? 8'h38 : 8'h00, "counter_restart", e);
`endif

    // reset_ring on the LDA T5 edge drops only the idle T6: result arrives one edge early.
    apply_stimulus(1'b1, 1'b1, 1'b1, 8'h00, "reset2", 0);
    for (int e = 1; e <= 40; e++)
      apply_stimulus(1'b0, (e == 5), 1'b0, (e >= 27) ? 8'h38 : 8'h00, "ring_restart", e);

    // clear_ir on the SUB T3 edge turns it into LDA 0, so A = ROM[0] = 0x09 gets output.
    apply_stimulus(1'b1, 1'b1, 1'b1, 8'h00, "reset3", 0);
    for (int e = 1; e <= 40; e++)
      apply_stimulus(1'b0, 1'b0, (e == 21), (e >= 28) ? 8'h09 : 8'h00, "clear_ir", e);

    @(negedge clk);
    @(negedge clk);
    if (sb.size() != 0) begin
      check_count++;
      $display("[TB] FAIL drain: pending=%0d expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
